alu_result_stage: RTL and testbench

Execute-stage output register directly downstream of the ALU. Captures each ALU result, destination tag and status (zero/sign/overflow) behind a valid/ready handshake, using a 2-entry skid buffer so ALU-side ready never depends combinationally on downstream ready. Holds the architectural flag register and evaluates branch conditions from it for the fetch/branch logic.

---
 rtl/alu_pkg.sv | 37 +++
 rtl/result_skid_buf.sv | 75 +++++++
 rtl/alu_result_stage.sv | 91 +++++++++
 tb/tb_alu_result_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ALU package: operation codes shared with the ALU, plus the branch
// condition codes and flag-register layout used by the result stage.
//   alu_op_e : ALU control code (arithmetic ops have bit 1 clear)
//   cond_e   : branch condition select evaluated on the flag register
//   flags_t  : architectural flag register {zero, sign, overflow}
package alu_pkg;

    typedef enum logic [1:0] {
        ALU_ADD      = 2'd0,
        ALU_SUBTRACT = 2'd1,
        ALU_BITW_OR  = 2'd2,
        ALU_BITW_AND = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        COND_ALWAYS = 3'd0,
        COND_EQ     = 3'd1,
        COND_NE     = 3'd2,
        COND_LT     = 3'd3,
        COND_GE     = 3'd4,
        COND_OVF    = 3'd5,
        COND_NEG    = 3'd6,
        COND_NEVER  = 3'd7
    } cond_e;

    typedef struct packed {
        logic zero;
        logic sign;
        logic overflow;
    } flags_t;

    // Logical ops (or/and) cannot overflow; they share op bit 1.
    function automatic logic is_logical_op(input alu_op_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/result_skid_buf.sv
// Generic 2-entry skid buffer.
//   in_valid/in_ready/in_data    : upstream handshake; in_ready is a flop
//   out_valid/out_ready/out_data : downstream handshake, head = main entry
//   flush                        : drop both entries at the next edge
//   occupancy                    : entries held (0..2)
// Upstream ready is ~skid_vld taken from a register, so it never depends
// combinationally on out_ready.
module result_skid_buf #(
    parameter int PAYLOAD_W = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy
);

    logic                 main_vld, skid_vld, rdy_q;
    logic                 main_vld_nx, skid_vld_nx;
    logic [PAYLOAD_W-1:0] main_data, skid_data;
    logic [PAYLOAD_W-1:0] main_data_nx, skid_data_nx;
    logic                 accept, drain;

    assign accept = in_valid & rdy_q;
    assign drain  = main_vld & out_ready;

    always_comb begin
        main_vld_nx  = main_vld;
        skid_vld_nx  = skid_vld;
        main_data_nx = main_data;
        skid_data_nx = skid_data;
        if (flush) begin
            // Data registers are left alone so outputs hold while invalid.
            main_vld_nx = 1'b0;
            skid_vld_nx = 1'b0;
        end else if (drain && skid_vld) begin
            // in_ready is low here, so no accept can collide with the move.
            main_data_nx = skid_data;
            skid_vld_nx  = 1'b0;
        end else if (drain || !main_vld) begin
            main_vld_nx = accept;
            if (accept) main_data_nx = in_data;
        end else if (accept) begin
            skid_vld_nx  = 1'b1;
            skid_data_nx = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_vld  <= 1'b0;
            skid_vld  <= 1'b0;
            rdy_q     <= 1'b1;
            main_data <= '0;
            skid_data <= '0;
        end else begin
            main_vld  <= main_vld_nx;
            skid_vld  <= skid_vld_nx;
            rdy_q     <= ~skid_vld_nx;
            main_data <= main_data_nx;
            skid_data <= skid_data_nx;
        end
    end

    assign in_ready  = rdy_q;
    assign out_valid = main_vld;
    assign out_data  = main_data;
    assign occupancy = {1'b0, main_vld} + {1'b0, skid_vld};

endmodule

// File: rtl/alu_result_stage.sv
// Execute-stage output register behind the ALU.
//   in_*      : ALU result, status, op code, flag-write enable, dest tag
//   out_*     : head-of-buffer result and dest tag (qualify with out_valid)
//   flush     : discard buffered results at the next edge
//   occupancy : entries held (0..2)
//   flags     : {zero, sign, overflow} architectural flag register
//   cond_sel  : branch condition select; cond_true is its value on flags
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_result,
    input  logic              in_zero,
    input  logic              in_sign,
    input  logic              in_overflow,
    input  logic [1:0]        in_op,
    input  logic              in_flags_we,
    input  logic [TAG_W-1:0]  in_dest,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_dest,
    output logic [1:0]        occupancy,
    output logic [2:0]        flags,
    input  logic [2:0]        cond_sel,
    output logic              cond_true
);

    localparam int PAYLOAD_W = DATA_W + TAG_W;

    logic [PAYLOAD_W-1:0] head_data;
    logic                 accept;
    flags_t               flags_q;
    cond_e                cond;

    result_skid_buf #(
        .PAYLOAD_W (PAYLOAD_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   ({in_result, in_dest}),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head_data),
        .occupancy (occupancy)
    );

    assign {out_result, out_dest} = head_data;
    assign accept = in_valid & in_ready;

    // Flags follow program order: they change when the producing result is
    // accepted, not when it drains. A flushed accept never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
        end else if (accept && in_flags_we && !flush) begin
            flags_q.zero     <= in_zero;
            flags_q.sign     <= in_sign;
            flags_q.overflow <= in_overflow & ~is_logical_op(alu_op_e'(in_op));
        end
    end

    assign flags = flags_q;
    assign cond  = cond_e'(cond_sel);

    always_comb begin
        cond_true = 1'b0;
        case (cond)
            COND_ALWAYS: cond_true = 1'b1;
            COND_EQ:     cond_true = flags_q.zero;
            COND_NE:     cond_true = ~flags_q.zero;
            COND_LT:     cond_true = flags_q.sign ^ flags_q.overflow;
            COND_GE:     cond_true = ~(flags_q.sign ^ flags_q.overflow);
            COND_OVF:    cond_true = flags_q.overflow;
            COND_NEG:    cond_true = flags_q.sign;
            COND_NEVER:  cond_true = 1'b0;
            default:     cond_true = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic        clk, rst_n;
    logic        in_valid, in_ready;
    logic [15:0] in_result;
    logic        in_zero, in_sign, in_overflow;
    logic [1:0]  in_op;
    logic        in_flags_we;
    logic [3:0]  in_dest;
    logic        flush;
    logic        out_valid, out_ready;
    logic [15:0] out_result;
    logic [3:0]  out_dest;
    logic [1:0]  occupancy;
    logic [2:0]  flags;
    logic [2:0]  cond_sel;
    logic        cond_true;

    alu_result_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_result   (in_result),
        .in_zero     (in_zero),
        .in_sign     (in_sign),
        .in_overflow (in_overflow),
        .in_op       (in_op),
        .in_flags_we (in_flags_we),
        .in_dest     (in_dest),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_dest    (out_dest),
        .occupancy   (occupancy),
        .flags       (flags),
        .cond_sel    (cond_sel),
        .cond_true   (cond_true)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: FIFO of {result, dest}, capacity 2, plus flag register.
    logic [19:0] q[$];
    logic [2:0]  m_flags;
    int          n_tests = 0;
    int          n_fail  = 0;
    logic        saved_eq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic cond_ref(input logic [2:0] sel, input logic [2:0] f);
        logic z, s, v;
        {z, s, v} = f;
        case (sel)
            3'd0: return 1'b1;
            3'd1: return z;
            3'd2: return !z;
            3'd3: return s != v;
            3'd4: return s == v;
            3'd5: return v;
            3'd6: return s;
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all();
        check_eq("out_valid", out_valid, q.size() != 0);
        check_eq("occupancy", occupancy, q.size());
        check_eq("in_ready", in_ready, q.size() < 2);
        check_eq("flags", flags, m_flags);
        check_eq("cond_true", cond_true, cond_ref(cond_sel, m_flags));
        if (q.size() != 0) begin
            check_eq("out_result", out_result, q[0][19:4]);
            check_eq("out_dest", out_dest, q[0][3:0]);
        end
    endtask

    // One clock: update the model at the edge, check outputs at the next negedge.
    task automatic step();
        logic acc, drn;
        @(posedge clk);
        acc = in_valid && (q.size() < 2);
        drn = (q.size() != 0) && out_ready;
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back({in_result, in_dest});
            if (acc && in_flags_we)
                m_flags = {in_zero, in_sign, in_overflow && (in_op < 2'd2)};
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic drive(input logic v, input logic [15:0] res, input logic [3:0] dest,
                         input logic z, input logic s, input logic o,
                         input logic [1:0] op, input logic we);
        in_valid = v; in_result = res; in_dest = dest;
        in_zero = z; in_sign = s; in_overflow = o; in_op = op; in_flags_we = we;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; cond_sel = 3'd0;
        drive(0, 16'h0, 4'h0, 0, 0, 0, 2'd0, 0);
        m_flags = 3'b000;
        repeat (2) @(negedge clk);
        check_all();
        check_eq("reset_out_result", out_result, 16'h0);
        check_eq("reset_out_dest", out_dest, 4'h0);
        rst_n = 1'b1;

        // Back-pressure: two results held, drained in order
        drive(1, 16'h0011, 4'h1, 0, 0, 0, 2'd0, 0);
        step();
        drive(1, 16'h0022, 4'h2, 0, 0, 0, 2'd0, 0);
        step();
        check_eq("bp_occ", occupancy, 2);
        check_eq("bp_ready", in_ready, 0);
        check_eq("bp_head0", out_result, 16'h0011);
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check_eq("bp_head1", out_result, 16'h0022);
        check_eq("bp_ready_after", in_ready, 1);

        // Streaming: results 1..8 one cycle after input
        for (int i = 1; i <= 8; i++) begin
            drive(1, 16'(i), 4'(i), 0, 0, 0, 2'd0, 0);
            step();
            check_eq("stream_result", out_result, i);
            check_eq("stream_occ_le1", occupancy <= 2'd1, 1);
        end
        in_valid = 1'b0;
        step();

        // Flags: add sets overflow, bitw_and forces it clear
        drive(1, 16'h8000, 4'h3, 0, 1, 1, 2'd0, 1);
        step();
        check_eq("flags_add", flags, 3'b011);
        cond_sel = 3'd3; #1;
        check_eq("cond_lt", cond_true, 0);
        cond_sel = 3'd6; #1;
        check_eq("cond_neg", cond_true, 1);
        drive(1, 16'h8001, 4'h4, 0, 1, 1, 2'd3, 1);
        step();
        check_eq("flags_and", flags, 3'b010);

        // Flush with same-cycle accept: dropped, flags untouched
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        drive(1, 16'h0055, 4'h5, 0, 0, 0, 2'd0, 0);
        step();
        check_eq("pre_flush_occ", occupancy, 1);
        drive(1, 16'h0000, 4'h6, 1, 0, 0, 2'd1, 1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check_eq("flush_occ", occupancy, 0);
        check_eq("flush_flags", flags, 3'b010);

        // flags_we=0: result forwarded, flags and eq unchanged
        out_ready = 1'b1; cond_sel = 3'd1;
        saved_eq = cond_true;
        drive(1, 16'h1234, 4'h7, 1, 0, 0, 2'd1, 0);
        step();
        check_eq("nowe_result", out_result, 16'h1234);
        check_eq("nowe_flags", flags, 3'b010);
        check_eq("nowe_eq", cond_true, saved_eq);

        // Asynchronous reset with two entries held
        in_valid = 1'b0;
        step();
        out_ready = 1'b0;
        drive(1, 16'h0aaa, 4'h8, 1, 0, 0, 2'd0, 1);
        step();
        drive(1, 16'h0bbb, 4'h9, 1, 0, 0, 2'd0, 1);
        step();
        check_eq("pre_rst_occ", occupancy, 2);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_in_ready", in_ready, 1);
        check_eq("arst_occ", occupancy, 0);
        check_eq("arst_flags", flags, 3'b000);
        q.delete();
        m_flags = 3'b000;
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 1), 16'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            cond_sel  = 3'($urandom);
            #1;
            check_eq("rnd_cond", cond_true, cond_ref(cond_sel, m_flags));
            step();
        end
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
